// File: rtl/data_mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter_if
// Purpose  : One requester's access channel into the data memory arbiter.
//            The requester drives the request fields. The arbiter returns the
//            grant pulse, the completion pulse, the load data and the error flag.
// Ports    : req, we, size[1:0], is_unsigned, addr[31:0], wdata[31:0]
//                (requester -> arbiter)
//            gnt, rvalid, rdata[31:0], err
//                (arbiter -> requester)
// Revision : 1.0  initial release
// ============================================================================
interface data_mem_arbiter_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, size, is_unsigned, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, size, is_unsigned, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Purpose  : Shares one single-port byte-addressed data memory between two
//            requesters (m0 = CPU load/store unit, m1 = debug/loader).
//            - Arbitration is round-robin, and one transaction runs at a time.
//            - Byte, halfword and word accesses become aligned word accesses.
//            - Stores use read-modify-write.
//            - Loads extract the addressed lane(s), then sign- or
//              zero-extend the result.
// Ports    : clk, rst           clock, asynchronous active-high reset
//            m0, m1             requester channels (slave modport)
//            mem_addr_o[31:0]   word-aligned byte address to memory
//            mem_wd_o[31:0]     merged write word
//            mem_we_o           memory write enable
//            mem_rd_i[31:0]     combinational read data from mem_addr_o
// Revision : 1.0  initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int MEM_BYTES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_arbiter_if.slave    m0,
    data_mem_arbiter_if.slave    m1,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_wd_o,
    output logic                 mem_we_o,
    input  logic [31:0]          mem_rd_i
);

    // Highest byte address that can still start a full word access.
    localparam logic [31:0] c_ADDR_MAX = 32'(MEM_BYTES - 4);

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q;
    logic        rr_last_q;   // requester that won the most recent contended grant
    logic        owner_q;     // 0 = m0, 1 = m1
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] buf_q;       // word read from memory during READ

    // ------------------------------------------------------------------
    // Arbitration. A tie goes to the requester that did not win last time.
    // Grants are gated by rst so that every output is 0 while in reset.
    // ------------------------------------------------------------------
    logic grant0;
    logic grant1;
    logic idle_ok;

    assign idle_ok = (state_q == S_IDLE) && !rst;
    assign grant0  = idle_ok && m0.req && (!m1.req || rr_last_q);
    assign grant1  = idle_ok && m1.req && (!m0.req || !rr_last_q);

    // Fields of the winning request.
    logic        sel_we;
    logic [1:0]  sel_size;
    logic        sel_uns;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;

    always_comb begin
        sel_we    = m0.we;
        sel_size  = m0.size;
        sel_uns   = m0.is_unsigned;
        sel_addr  = m0.addr;
        sel_wdata = m0.wdata;
        if (grant1) begin
            sel_we    = m1.we;
            sel_size  = m1.size;
            sel_uns   = m1.is_unsigned;
            sel_addr  = m1.addr;
            sel_wdata = m1.wdata;
        end
    end

    always_comb begin
        sel_err = 1'b0;
        if (sel_size == 2'b11) begin
            sel_err = 1'b1;
        end
        if ((sel_size == c_SIZE_HALF) && sel_addr[0]) begin
            sel_err = 1'b1;
        end
        if ((sel_size == c_SIZE_WORD) && (sel_addr[1:0] != 2'b00)) begin
            sel_err = 1'b1;
        end
        if (sel_addr > c_ADDR_MAX) begin
            sel_err = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM. Each transaction state lasts exactly one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_last_q <= 1'b1;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            err_q     <= 1'b0;
            buf_q     <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant0 || grant1) begin
                        owner_q <= grant1;
                        we_q    <= sel_we;
                        size_q  <= sel_size;
                        uns_q   <= sel_uns;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        err_q   <= sel_err;
                        if (m0.req && m1.req) begin
                            rr_last_q <= grant1;
                        end
                        state_q <= sel_err ? S_RESP : S_READ;
                    end
                end
                S_READ: begin
                    buf_q   <= mem_rd_i;
                    state_q <= we_q ? S_WRITE : S_RESP;
                end
                S_WRITE: begin
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Store merge: replace the addressed lane(s) of the word that was read.
    // ------------------------------------------------------------------
    logic [31:0] merged_word;

    always_comb begin
        merged_word = buf_q;
        case (size_q)
            c_SIZE_BYTE: merged_word[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            c_SIZE_HALF: merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            c_SIZE_WORD: merged_word = wdata_q;
            default:     merged_word = buf_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction. A halfword is always 2-byte aligned once it gets
    // past the error check, so one byte-granular shift covers both sizes.
    // ------------------------------------------------------------------
    logic [31:0] shifted_word;
    logic [31:0] load_ext;
    logic [31:0] load_data;

    assign shifted_word = buf_q >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = shifted_word;
        case (size_q)
            c_SIZE_BYTE: load_ext = uns_q ? {24'd0, shifted_word[7:0]}
                                          : {{24{shifted_word[7]}}, shifted_word[7:0]};
            c_SIZE_HALF: load_ext = uns_q ? {16'd0, shifted_word[15:0]}
                                          : {{16{shifted_word[15]}}, shifted_word[15:0]};
            default:     load_ext = shifted_word;
        endcase
    end

    assign load_data = (we_q || err_q) ? 32'd0 : load_ext;

    // ------------------------------------------------------------------
    // Outputs, decoded from state. An asynchronous reset forces IDLE, so the
    // memory write enable and any pending response drop at once.
    // ------------------------------------------------------------------
    logic resp0;
    logic resp1;

    assign resp0 = (state_q == S_RESP) && !owner_q;
    assign resp1 = (state_q == S_RESP) &&  owner_q;

    assign m0.gnt    = grant0;
    assign m0.rvalid = resp0;
    assign m0.err    = resp0 && err_q;
    assign m0.rdata  = resp0 ? load_data : 32'd0;

    assign m1.gnt    = grant1;
    assign m1.rvalid = resp1;
    assign m1.err    = resp1 && err_q;
    assign m1.rdata  = resp1 ? load_data : 32'd0;

    assign mem_addr_o = ((state_q == S_READ) || (state_q == S_WRITE))
                        ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_we_o   = (state_q == S_WRITE);
    assign mem_wd_o   = (state_q == S_WRITE) ? merged_word : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Purpose  : Self-checking bench for data_mem_arbiter. A byte-array memory
//            model serves the DUT's memory port. A separate byte-array
//            reference model predicts load data, errors and latencies.
// Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_arbiter;
    localparam int          MEM_BYTES  = 1024;
    localparam logic [31:0] c_ADDR_MAX = 32'(MEM_BYTES - 4);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_arbiter_if m0_if();
    data_mem_arbiter_if m1_if();

    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    data_mem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0         (m0_if),
        .m1         (m1_if),
        .mem_addr_o (mem_addr),
        .mem_wd_o   (mem_wd),
        .mem_we_o   (mem_we),
        .mem_rd_i   (mem_rd)
    );

    // ---------------- memory attached to the DUT ----------------
    logic [7:0] dut_mem [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    logic       load_en = 1'b1;
    logic [9:0] mem_idx;

    assign mem_idx = mem_addr[9:0];

    always_comb begin
        mem_rd = 32'd0;
        if (mem_addr <= c_ADDR_MAX) begin
            mem_rd = {dut_mem[mem_idx + 10'd3], dut_mem[mem_idx + 10'd2],
                      dut_mem[mem_idx + 10'd1], dut_mem[mem_idx]};
        end
    end

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < MEM_BYTES; i++) dut_mem[i] <= ref_mem[i];
        end else if (mem_we && (mem_addr <= c_ADDR_MAX)) begin
            dut_mem[mem_idx]          <= mem_wd[7:0];
            dut_mem[mem_idx + 10'd1]  <= mem_wd[15:8];
            dut_mem[mem_idx + 10'd2]  <= mem_wd[23:16];
            dut_mem[mem_idx + 10'd3]  <= mem_wd[31:24];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Observations from run_txn.
    int          obs_wait;
    int          obs_lat;
    logic [31:0] obs_rdata;
    logic        obs_err;
    bit          obs_stray;
    bit          obs_wrote;
    bit          obs_timeout;

    // Expectations from model_txn.
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;

    // ---------------- helpers ----------------
    task automatic drive(input int p, input logic req, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            m0_if.req = req; m0_if.we = we; m0_if.size = size;
            m0_if.is_unsigned = uns; m0_if.addr = addr; m0_if.wdata = wdata;
        end else begin
            m1_if.req = req; m1_if.we = we; m1_if.size = size;
            m1_if.is_unsigned = uns; m1_if.addr = addr; m1_if.wdata = wdata;
        end
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 0) ? m0_if.gnt : m1_if.gnt;
    endfunction
    function automatic logic rv_of(input int p);
        return (p == 0) ? m0_if.rvalid : m1_if.rvalid;
    endfunction
    function automatic logic err_of(input int p);
        return (p == 0) ? m0_if.err : m1_if.err;
    endfunction
    function automatic logic [31:0] rdata_of(input int p);
        return (p == 0) ? m0_if.rdata : m1_if.rdata;
    endfunction

    // Reference model: byte-array memory plus the access rules.
    task automatic model_txn(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int          n;
        logic [31:0] v;
        n = 1 << size;
        exp_err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                  (size == 2'b10 && addr[1:0] != 2'b00) || (addr > c_ADDR_MAX);
        exp_rdata = 32'd0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (we) begin
            exp_lat = 3;
            for (int i = 0; i < n; i++) ref_mem[10'(addr + 32'(i))] = wdata[8*i +: 8];
        end else begin
            exp_lat = 2;
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[10'(addr + 32'(i))]) << (8*i));
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            exp_rdata = v;
        end
    endtask

    // Issue one request on port p and observe it through to rvalid.
    task automatic run_txn(input int p, input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bit got;
        got = 1'b0; obs_wait = 0; obs_lat = 0; obs_rdata = 32'd0; obs_err = 1'b0;
        obs_stray = 1'b0; obs_wrote = 1'b0; obs_timeout = 1'b0;
        @(posedge clk); #1;
        drive(p, 1'b1, we, size, uns, addr, wdata);
        while (!got && !obs_timeout) begin
            @(negedge clk);
            if (gnt_of(1-p) || rv_of(1-p)) obs_stray = 1'b1;
            if (gnt_of(p)) got = 1'b1;
            else begin
                obs_wait = obs_wait + 1;
                if (obs_wait > 20) obs_timeout = 1'b1;
            end
        end
        if (got) begin
            @(posedge clk); #1;
            drive(p, 1'b0, we, size, uns, addr, wdata);
            got = 1'b0;
            while (!got && !obs_timeout) begin
                @(negedge clk);
                obs_lat = obs_lat + 1;
                if (mem_we) obs_wrote = 1'b1;
                if (gnt_of(1-p) || rv_of(1-p) || err_of(1-p) || rdata_of(1-p) != 32'd0)
                    obs_stray = 1'b1;
                if (rv_of(p)) begin
                    got = 1'b1; obs_rdata = rdata_of(p); obs_err = err_of(p);
                end else if (obs_lat > 10) obs_timeout = 1'b1;
            end
        end else begin
            drive(p, 1'b0, we, size, uns, addr, wdata);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        n_checks++; if (m0_if.gnt !== 1'b0) begin n_fail++; $display("FAIL reset_m0_gnt: got %b want 0", m0_if.gnt); end
        n_checks++; if (m1_if.gnt !== 1'b0) begin n_fail++; $display("FAIL reset_m1_gnt: got %b want 0", m1_if.gnt); end
        n_checks++; if ({m0_if.rvalid, m1_if.rvalid, m0_if.err, m1_if.err} !== 4'b0) begin
            n_fail++; $display("FAIL reset_rvalid_err: got %b want 0000", {m0_if.rvalid, m1_if.rvalid, m0_if.err, m1_if.err}); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_checks++; if (mem_wd !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wd: got %h want 0", mem_wd); end
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_word_rw();
        run_txn(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        model_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        n_checks++; if (obs_timeout || obs_wait != 0) begin n_fail++; $display("FAIL sw_grant: wait %0d timeout %0d want wait 0", obs_wait, obs_timeout); end
        n_checks++; if (obs_lat != 3) begin n_fail++; $display("FAIL sw_latency: got %0d want 3", obs_lat); end
        n_checks++; if ({obs_err, obs_rdata} !== 33'd0) begin n_fail++; $display("FAIL sw_resp: err %b rdata %h want 0/0", obs_err, obs_rdata); end
        run_txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        n_checks++; if (obs_lat != 2) begin n_fail++; $display("FAIL lw_latency: got %0d want 2", obs_lat); end
        n_checks++; if (obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL lw_rdata: got %h err %b want deadbeef err 0", obs_rdata, obs_err); end
        n_checks++; if (obs_stray || obs_wrote) begin n_fail++; $display("FAIL lw_side: stray %0d wrote %0d want 0/0", obs_stray, obs_wrote); end
    endtask

    task automatic test_byte_half();
        logic [31:0] w;
        run_txn(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
        model_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
        run_txn(1, 1'b1, 2'b00, 1'b0, 32'h13, 32'hABCDEF80);
        model_txn(1'b1, 2'b00, 1'b0, 32'h13, 32'hABCDEF80);
        w = {dut_mem[10'h13], dut_mem[10'h12], dut_mem[10'h11], dut_mem[10'h10]};
        n_checks++; if (w !== 32'h80223344) begin n_fail++; $display("FAIL sb_merge: mem got %h want 80223344", w); end
        run_txn(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        n_checks++; if (obs_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_sext: got %h want ffffff80", obs_rdata); end
        run_txn(1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        n_checks++; if (obs_rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu_zext: got %h want 00000080", obs_rdata); end
        run_txn(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        n_checks++; if (obs_rdata !== 32'hFFFF8022) begin n_fail++; $display("FAIL lh_sext: got %h want ffff8022", obs_rdata); end
        run_txn(0, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        n_checks++; if (obs_rdata !== 32'h00003344) begin n_fail++; $display("FAIL lhu_low: got %h want 00003344", obs_rdata); end
    endtask

    task automatic test_errors();
        logic [1:0]  sz [4];
        logic [31:0] ad [4];
        sz = '{2'b01, 2'b10, 2'b11, 2'b10};
        ad = '{32'h11, 32'h12, 32'h10, 32'(MEM_BYTES)};
        for (int i = 0; i < 8; i++) begin
            run_txn(i % 2, 1'(i / 4), sz[i % 4], 1'b0, ad[i % 4], 32'hFFFF_FFFF);
            model_txn(1'(i / 4), sz[i % 4], 1'b0, ad[i % 4], 32'hFFFF_FFFF);
            n_checks++; if (obs_timeout || obs_lat != exp_lat || obs_lat != 1) begin
                n_fail++; $display("FAIL err_latency[%0d]: got %0d want 1", i, obs_lat); end
            n_checks++; if (obs_err !== 1'b1 || obs_rdata !== 32'd0) begin
                n_fail++; $display("FAIL err_resp[%0d]: err %b rdata %h want 1/0", i, obs_err, obs_rdata); end
            n_checks++; if (obs_wrote || obs_stray) begin
                n_fail++; $display("FAIL err_side[%0d]: wrote %0d stray %0d want 0/0", i, obs_wrote, obs_stray); end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] w0, w1, rd;
        int gcnt, rcnt, gcyc, pend, exp_owner, cyc;
        bit g0, g1, r0, r1, drop_pending;
        model_txn(1'b0, 2'b10, 1'b0, 32'h40, 32'h0); w0 = exp_rdata;
        model_txn(1'b0, 2'b10, 1'b0, 32'h80, 32'h0); w1 = exp_rdata;
        apply_reset();
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
        gcnt = 0; rcnt = 0; exp_owner = 0; pend = -1; gcyc = 0; cyc = 0; drop_pending = 1'b0;
        while (rcnt < 4 && cyc < 60) begin
            if (drop_pending) begin
                @(posedge clk); #1;
                drive(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
                drive(1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
                drop_pending = 1'b0;
            end
            @(negedge clk);
            g0 = m0_if.gnt; g1 = m1_if.gnt; r0 = m0_if.rvalid; r1 = m1_if.rvalid;
            rd = r1 ? m1_if.rdata : m0_if.rdata;
            if ((g0 && g1) || (r0 && r1)) begin
                n_checks++; n_fail++; $display("FAIL rr_exclusive: gnt %b%b rvalid %b%b want one-hot", g0, g1, r0, r1);
            end
            if (g0 || g1) begin
                n_checks++; if (int'(g1) != exp_owner) begin
                    n_fail++; $display("FAIL rr_order[%0d]: got m%0d want m%0d", gcnt, int'(g1), exp_owner); end
                pend = int'(g1); gcyc = cyc; exp_owner = 1 - exp_owner; gcnt++;
                if (gcnt == 4) drop_pending = 1'b1;
            end
            if (r0 || r1) begin
                n_checks++; if (int'(r1) != pend || cyc - gcyc != 2) begin
                    n_fail++; $display("FAIL rr_rvalid[%0d]: got m%0d at +%0d want m%0d at +2", rcnt, int'(r1), cyc - gcyc, pend); end
                n_checks++; if (rd !== ((pend == 1) ? w1 : w0)) begin
                    n_fail++; $display("FAIL rr_rdata[%0d]: got %h want %h", rcnt, rd, (pend == 1) ? w1 : w0); end
                rcnt++;
            end
            cyc++;
        end
        n_checks++; if (rcnt != 4) begin n_fail++; $display("FAIL rr_count: got %0d completions want 4", rcnt); end
        if (drop_pending) begin
            @(posedge clk); #1;
            drive(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
            drive(1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
        end
    endtask

    task automatic test_reset_mid_write();
        bit got, seen;
        int k;
        logic [31:0] w, rd;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
        got = 1'b0; k = 0;
        while (!got && k < 10) begin
            @(negedge clk);
            if (m0_if.gnt) got = 1'b1;
            k++;
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL rstw_grant: got none want m0 gnt"); end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
        @(posedge clk); #1;
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rstw_in_write: mem_we got %b want 1", mem_we); end
        rst = 1'b1;
        #1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rstw_we_drop: mem_we got %b want 0", mem_we); end
        @(negedge clk);
        @(negedge clk);
        w = {dut_mem[10'h23], dut_mem[10'h22], dut_mem[10'h21], dut_mem[10'h20]};
        n_checks++; if (w !== 32'd0) begin n_fail++; $display("FAIL rstw_mem: got %h want 00000000", w); end
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (m0_if.rvalid || m1_if.rvalid) seen = 1'b1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL rstw_no_rvalid: got rvalid want none"); end
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        n_checks++; if ({m0_if.gnt, m1_if.gnt} !== 2'b10) begin
            n_fail++; $display("FAIL rstw_first_gnt: got m0/m1 %b%b want 10", m0_if.gnt, m1_if.gnt); end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        got = 1'b0; k = 0; rd = 32'hFFFF_FFFF;
        while (!got && k < 10) begin
            @(negedge clk);
            if (m0_if.rvalid) begin got = 1'b1; rd = m0_if.rdata; end
            k++;
        end
        n_checks++; if (!got || rd !== 32'd0) begin n_fail++; $display("FAIL rstw_readback: got %h done %0d want 00000000", rd, got); end
    endtask

    task automatic test_late_request();
        int cyc, m1g, m1r, m0g, m0r;
        logic [31:0] rd, w80;
        model_txn(1'b0, 2'b10, 1'b0, 32'h80, 32'h0); w80 = exp_rdata;
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        cyc = 0; m1g = -1; m1r = -1; m0g = -1; m0r = -1; rd = 32'd0;
        while (m0r < 0 && cyc < 20) begin
            @(negedge clk);
            if (m1_if.gnt && m1g < 0) m1g = cyc;
            if (m1_if.rvalid && m1r < 0) m1r = cyc;
            if (m0_if.gnt && m0g < 0) m0g = cyc;
            if (m0_if.rvalid) begin m0r = cyc; rd = m0_if.rdata; end
            @(posedge clk); #1;
            if (cyc == m1g) begin
                drive(1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
                drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
            end
            if (cyc == m0g) drive(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
            cyc++;
        end
        n_checks++; if (m1g != 0 || m1r != 2) begin n_fail++; $display("FAIL late_m1: gnt %0d rvalid %0d want 0/2", m1g, m1r); end
        n_checks++; if (m0g != 3) begin n_fail++; $display("FAIL late_m0_gnt: got cycle %0d want 3", m0g); end
        n_checks++; if (m0r != 5 || rd !== w80) begin n_fail++; $display("FAIL late_m0_resp: cycle %0d rdata %h want 5/%h", m0r, rd, w80); end
        drive(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    endtask

    task automatic test_random();
        int p, r, diffs;
        logic we, uns;
        logic [1:0] size;
        logic [31:0] addr, wdata;
        for (int it = 0; it < 150; it++) begin
            p = int'($urandom % 2);
            we = 1'($urandom % 2);
            uns = 1'($urandom % 2);
            r = int'($urandom % 16);
            size = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
            addr = 32'($urandom_range(0, MEM_BYTES + 7));
            if ($urandom % 4 != 0) addr = addr & ~((32'd1 << size) - 32'd1);
            wdata = $urandom;
            run_txn(p, we, size, uns, addr, wdata);
            model_txn(we, size, uns, addr, wdata);
            n_checks++; if (obs_timeout || obs_wait != 0 || obs_lat != exp_lat) begin
                n_fail++; $display("FAIL rnd_timing[%0d]: wait %0d lat %0d want 0/%0d (addr %h size %0d we %0d)", it, obs_wait, obs_lat, exp_lat, addr, size, we); end
            n_checks++; if (obs_err !== exp_err || obs_rdata !== exp_rdata) begin
                n_fail++; $display("FAIL rnd_resp[%0d]: err %b rdata %h want %b/%h (addr %h size %0d uns %0d we %0d)", it, obs_err, obs_rdata, exp_err, exp_rdata, addr, size, uns, we); end
            n_checks++; if (obs_stray || (obs_wrote != (we && !exp_err))) begin
                n_fail++; $display("FAIL rnd_side[%0d]: stray %0d wrote %0d want 0/%0d", it, obs_stray, obs_wrote, we && !exp_err); end
        end
        diffs = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (dut_mem[i] !== ref_mem[i]) diffs++;
        n_checks++; if (diffs != 0) begin n_fail++; $display("FAIL mem_image: %0d bytes differ want 0", diffs); end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
        for (int i = 32'h20; i < 32'h24; i++) ref_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1 load_en = 1'b0;
        test_reset();
        test_word_rw();
        test_byte_half();
        test_errors();
        test_round_robin();
        test_reset_mid_write();
        test_late_request();
        test_random();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
